seg_display_ctrl: RTL

SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

---
 rtl/seg_pkg.sv | 72 +++++++
 rtl/seg_display_ctrl_bin2bcd.sv | 75 +++++++
 rtl/seg_display_ctrl.sv | 72 +++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared encodings, character codes, FSM state type and helpers for the
// four-digit seven-segment display controller.
package seg_pkg;

  localparam int unsigned VALUE_W   = 14;
  localparam int unsigned NIB_W     = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned BCD_W     = NIB_W * NUM_DIGITS;
  localparam int unsigned MODE_W    = 3;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned STEPS     = 14;
  localparam int unsigned MAX_VALUE = 9999;

  typedef enum logic [MODE_W-1:0] {
    MODE_NUM  = 3'd0,
    MODE_IDLE = 3'd1,
    MODE_RUN  = 3'd2,
    MODE_DONE = 3'd3,
    MODE_ERR  = 3'd4,
    MODE_OFF  = 3'd5
  } mode_e;

  localparam logic [NIB_W-1:0] CH_BLANK = 4'd0;
  localparam logic [NIB_W-1:0] CH_I     = 4'd1;
  localparam logic [NIB_W-1:0] CH_D     = 4'd2;
  localparam logic [NIB_W-1:0] CH_L     = 4'd3;
  localparam logic [NIB_W-1:0] CH_E     = 4'd4;
  localparam logic [NIB_W-1:0] CH_LO    = 4'd5;
  localparam logic [NIB_W-1:0] CH_N     = 4'd6;
  localparam logic [NIB_W-1:0] CH_R     = 4'd7;
  localparam logic [NIB_W-1:0] CH_U     = 4'd8;
  localparam logic [NIB_W-1:0] CH_UO    = 4'd9;
  localparam logic [NIB_W-1:0] CH_F     = 4'd10;
  localparam logic [NIB_W-1:0] CH_DASH  = 4'd15;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Payload of the display output register: codes plus per-digit char flags.
  typedef struct packed {
    logic [BCD_W-1:0]      bcd;
    logic [NUM_DIGITS-1:0] cflag;
  } disp_t;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] acc);
    logic [BCD_W-1:0] res;
    res = acc;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (acc[i*NIB_W +: NIB_W] >= NIB_W'(5)) begin
        res[i*NIB_W +: NIB_W] = acc[i*NIB_W +: NIB_W] + NIB_W'(3);
      end
    end
    return res;
  endfunction

  // Character codes for the message modes, digit3 in the top nibble.
  function automatic logic [BCD_W-1:0] msg_code(input logic [MODE_W-1:0] mode);
    logic [BCD_W-1:0] res;
    case (mode)
      MODE_IDLE: res = {CH_I, CH_D, CH_L, CH_E};
      MODE_RUN:  res = {CH_BLANK, CH_R, CH_U, CH_N};
      MODE_DONE: res = {CH_D, CH_LO, CH_N, CH_E};
      MODE_ERR:  res = {CH_E, CH_R, CH_R, CH_BLANK};
      default:   res = {CH_BLANK, CH_UO, CH_F, CH_F};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/seg_display_ctrl_bin2bcd.sv
// Sequential binary-to-BCD converter: one double-dabble step per cycle,
// 14 steps per conversion, result held in the number register.
module bin2bcd_seq
  import seg_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  output logic [BCD_W-1:0]   bcd,
  output logic               ovf,
  output logic               busy,
  output logic               done
);

  state_e             state;
  logic [VALUE_W-1:0] operand;
  logic [BCD_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf_pend;
  logic [BCD_W-1:0]   acc_adj;
  logic [BCD_W-1:0]   acc_step;

  always_comb begin
    acc_adj  = dd_adjust(acc);
    acc_step = {acc_adj[BCD_W-2:0], operand[VALUE_W-1]};
  end

  // Controller FSM and datapath; loads arriving while busy are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      operand  <= '0;
      acc      <= '0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      bcd      <= '0;
      ovf      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load) begin
            operand  <= value;
            acc      <= '0;
            cnt      <= CNT_W'(STEPS);
            ovf_pend <= (value > VALUE_W'(MAX_VALUE));
            state    <= ST_SHIFT;
            busy     <= 1'b1;
          end
        end
        ST_SHIFT: begin
          acc     <= acc_step;
          operand <= {operand[VALUE_W-2:0], 1'b0};
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            // Final step commits straight from the step result.
            bcd   <= ovf_pend ? {NUM_DIGITS{CH_DASH}} : acc_step;
            ovf   <= ovf_pend;
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/seg_display_ctrl.sv
// Four-digit display controller: number conversion plus mode mux, leading
// zero blanking and registered digit codes/flags for bcd_7segment decoders.
module seg_display_ctrl
  import seg_pkg::*;
#(
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [VALUE_W-1:0]    value,
  input  logic                  load,
  input  logic [MODE_W-1:0]     mode,
  output logic [BCD_W-1:0]      digit_bcd,
  output logic [NUM_DIGITS-1:0] digit_cflag,
  output logic                  busy,
  output logic                  done
);

  logic [BCD_W-1:0] num_bcd;
  logic             num_ovf;
  disp_t            disp_next;
  logic             z3;
  logic             z2;
  logic             z1;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .load  (load),
    .bcd   (num_bcd),
    .ovf   (num_ovf),
    .busy  (busy),
    .done  (done)
  );

  assign z3 = (num_bcd[15:12] == NIB_W'(0));
  assign z2 = (num_bcd[11:8]  == NIB_W'(0));
  assign z1 = (num_bcd[7:4]   == NIB_W'(0));

  // Mode mux; blanked digits keep code 0 and switch to the blank character.
  always_comb begin
    disp_next.bcd   = num_bcd;
    disp_next.cflag = '0;
    case (mode)
      MODE_NUM: begin
        if (num_ovf) begin
          disp_next.bcd = {NUM_DIGITS{CH_DASH}};
        end else begin
          disp_next.cflag[3] = LZ_BLANK & z3;
          disp_next.cflag[2] = LZ_BLANK & z3 & z2;
          disp_next.cflag[1] = LZ_BLANK & z3 & z2 & z1;
        end
      end
      default: begin
        disp_next.bcd   = msg_code(mode);
        disp_next.cflag = '1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_bcd   <= '0;
      digit_cflag <= '1;
    end else begin
      digit_bcd   <= disp_next.bcd;
      digit_cflag <= disp_next.cflag;
    end
  end

endmodule
